// File: rtl/jpeg_byte_stuffer.sv
// JPEG byte stuffer: word FIFO, MSB-first byte serialiser with 0xFF->0xFF,0x00 stuffing and
// 1-padded residual flush. Define EOI_APPEND_EN to append the 0xFFD9 EOI marker after the flush.
module jpeg_byte_stuffer #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FIFO_AW    = $clog2(FIFO_DEPTH)
) (
  input  logic        clk_x8_i,
  input  logic        rst_i,
  input  logic [31:0] word_i,
  input  logic        word_valid_i,
  input  logic        last_i,
  input  logic [31:0] left_i,
  input  logic [4:0]  left_len_i,
  output logic [7:0]  byte_o,
  output logic        byte_valid_o,
  input  logic        byte_ready_i,
  output logic        eoi_done_o,
  output logic        busy_o,
  output logic        overflow_o
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSend,
    StStuff,
    StFlush,
`ifdef EOI_APPEND_EN
    StEoiFf,
    StEoiD9,
`endif
    StDone
  } state_e;

  state_e           r_state, w_state_nxt, w_end_state;
  logic [31:0]      r_mem [FIFO_DEPTH];
  logic [FIFO_AW:0] r_wr_ptr, r_rd_ptr;
  logic             r_pending;
  logic [31:0]      r_left;
  logic [4:0]       r_left_len;
  logic [31:0]      r_word, w_word_nxt;
  logic [1:0]       r_idx, w_idx_nxt, w_idx_inc;
  logic [1:0]       r_last_idx, w_last_idx_nxt;
  logic             r_in_flush, w_in_flush_nxt;
  logic [7:0]       r_byte, w_byte_nxt, w_end_byte;
  logic             r_valid, w_valid_nxt, w_end_valid;
  logic             r_eoi_done, r_busy, r_overflow;

  logic             w_empty, w_full, w_push, w_pop, w_last_acc, w_ovf_evt;
  logic             w_xfer, w_cur_last;
  logic [31:0]      w_head, w_pad;
  logic [1:0]       w_nb;

  function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] k);
    logic [7:0] b;
    unique case (k)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                      (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
  // Full is judged on the current occupancy, so a pop in the same cycle does not make room.
  assign w_push     = word_valid_i && !w_full && !r_pending;
  assign w_last_acc = last_i && !r_pending;
  assign w_ovf_evt  = (word_valid_i && (w_full || r_pending)) || (last_i && r_pending);
  assign w_head     = r_mem[r_rd_ptr[FIFO_AW-1:0]];

  assign w_pad      = r_left | (32'hFFFF_FFFF >> r_left_len);
  assign w_nb       = 2'((r_left_len - 5'd1) >> 3);

  assign w_xfer     = r_valid && byte_ready_i;
  assign w_cur_last = (r_idx == r_last_idx);
  assign w_idx_inc  = r_idx + 2'd1;

  // Where a word or the residual goes once its final byte (and any stuffing) is accepted.
  always_comb begin
    w_end_state = StIdle;
    w_end_byte  = 8'h00;
    w_end_valid = 1'b0;
    if (r_in_flush) begin
`ifdef EOI_APPEND_EN
      w_end_state = StEoiFf;
      w_end_byte  = 8'hFF;
      w_end_valid = 1'b1;
`else
      w_end_state = StDone;
`endif
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_word_nxt     = r_word;
    w_idx_nxt      = r_idx;
    w_last_idx_nxt = r_last_idx;
    w_in_flush_nxt = r_in_flush;
    w_byte_nxt     = r_byte;
    w_valid_nxt    = r_valid;
    w_pop          = 1'b0;
    case (r_state)
      StIdle: begin
        if (!w_empty) begin
          w_state_nxt = StLoad;
        end else if (r_pending) begin
          if (r_left_len == 5'd0) begin
`ifdef EOI_APPEND_EN
            w_state_nxt = StEoiFf;
            w_byte_nxt  = 8'hFF;
            w_valid_nxt = 1'b1;
`else
            w_state_nxt = StDone;
`endif
          end else begin
            w_state_nxt    = StFlush;
            w_word_nxt     = w_pad;
            w_idx_nxt      = 2'd0;
            w_last_idx_nxt = w_nb;
            w_in_flush_nxt = 1'b1;
            w_byte_nxt     = w_pad[31:24];
            w_valid_nxt    = 1'b1;
          end
        end
      end
      StLoad: begin
        w_pop          = 1'b1;
        w_word_nxt     = w_head;
        w_idx_nxt      = 2'd0;
        w_last_idx_nxt = 2'd3;
        w_in_flush_nxt = 1'b0;
        w_byte_nxt     = w_head[31:24];
        w_valid_nxt    = 1'b1;
        w_state_nxt    = StSend;
      end
      StSend, StFlush: begin
        if (w_xfer) begin
          if (r_byte == 8'hFF) begin
            w_state_nxt = StStuff;
            w_byte_nxt  = 8'h00;
          end else if (w_cur_last) begin
            w_state_nxt = w_end_state;
            w_byte_nxt  = w_end_byte;
            w_valid_nxt = w_end_valid;
          end else begin
            w_idx_nxt  = w_idx_inc;
            w_byte_nxt = sel_byte(r_word, w_idx_inc);
          end
        end
      end
      StStuff: begin
        if (w_xfer) begin
          if (w_cur_last) begin
            w_state_nxt = w_end_state;
            w_byte_nxt  = w_end_byte;
            w_valid_nxt = w_end_valid;
          end else begin
            w_state_nxt = r_in_flush ? StFlush : StSend;
            w_idx_nxt   = w_idx_inc;
            w_byte_nxt  = sel_byte(r_word, w_idx_inc);
          end
        end
      end
`ifdef EOI_APPEND_EN
      StEoiFf: begin
        if (w_xfer) begin
          w_state_nxt = StEoiD9;
          w_byte_nxt  = 8'hD9;
        end
      end
      StEoiD9: begin
        if (w_xfer) begin
          w_state_nxt = StDone;
          w_byte_nxt  = 8'h00;
          w_valid_nxt = 1'b0;
        end
      end
`endif
      StDone: begin
        w_state_nxt    = StIdle;
        w_in_flush_nxt = 1'b0;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_x8_i) begin
    if (w_push) r_mem[r_wr_ptr[FIFO_AW-1:0]] <= word_i;
  end

  always_ff @(posedge clk_x8_i) begin
    if (rst_i) begin
      r_state    <= StIdle;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_pending  <= 1'b0;
      r_left     <= '0;
      r_left_len <= '0;
      r_word     <= '0;
      r_idx      <= '0;
      r_last_idx <= '0;
      r_in_flush <= 1'b0;
      r_byte     <= 8'h00;
      r_valid    <= 1'b0;
      r_eoi_done <= 1'b0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_word     <= w_word_nxt;
      r_idx      <= w_idx_nxt;
      r_last_idx <= w_last_idx_nxt;
      r_in_flush <= w_in_flush_nxt;
      r_byte     <= w_byte_nxt;
      r_valid    <= w_valid_nxt;
      r_eoi_done <= (r_state == StDone);
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_ovf_evt) r_overflow <= 1'b1;
      if (w_last_acc) begin
        r_pending  <= 1'b1;
        r_left     <= left_i;
        r_left_len <= left_len_i;
      end else if (r_state == StDone) begin
        r_pending  <= 1'b0;
        r_left     <= '0;
        r_left_len <= '0;
      end
      if (r_state == StDone)        r_busy <= 1'b0;
      else if (w_push || w_last_acc) r_busy <= 1'b1;
    end
  end

  assign byte_o       = r_byte;
  assign byte_valid_o = r_valid;
  assign eoi_done_o   = r_eoi_done;
  assign busy_o       = r_busy;
  assign overflow_o   = r_overflow;

endmodule

// File: tb/tb_jpeg_byte_stuffer.sv
// Self-checking bench for jpeg_byte_stuffer: directed cases plus randomized frames checked against
// a byte-queue reference model built from the stuffing/padding/EOI rules.
module tb_jpeg_byte_stuffer;

  logic        clk_x8_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] word_i = '0;
  logic        word_valid_i = 1'b0;
  logic        last_i = 1'b0;
  logic [31:0] left_i = '0;
  logic [4:0]  left_len_i = '0;
  logic [7:0]  byte_o;
  logic        byte_valid_o;
  logic        byte_ready_i = 1'b1;
  logic        eoi_done_o;
  logic        busy_o;
  logic        overflow_o;

  jpeg_byte_stuffer #(.FIFO_DEPTH(16)) dut (
    .clk_x8_i     (clk_x8_i),
    .rst_i        (rst_i),
    .word_i       (word_i),
    .word_valid_i (word_valid_i),
    .last_i       (last_i),
    .left_i       (left_i),
    .left_len_i   (left_len_i),
    .byte_o       (byte_o),
    .byte_valid_o (byte_valid_o),
    .byte_ready_i (byte_ready_i),
    .eoi_done_o   (eoi_done_o),
    .busy_o       (busy_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk_x8_i = ~clk_x8_i;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_rx    = 0;
  int         n_eoi   = 0;
  int         rdy_mode = 1;  // 0: ready low, 1: ready high, 2: random
  logic [7:0] exp_q[$];
  logic       hold_pending = 1'b0;
  logic [7:0] hold_byte = '0;
  logic       prev_eoi = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: expected output bytes appended in stream order.
  function automatic void add_byte(input logic [7:0] b);
    exp_q.push_back(b);
    if (b == 8'hFF) exp_q.push_back(8'h00);
  endfunction

  function automatic void model_word(input logic [31:0] w);
    logic [31:0] t;
    for (int i = 0; i < 4; i++) begin
      t = w >> (24 - 8 * i);
      add_byte(t[7:0]);
    end
  endfunction

  function automatic void model_last(input logic [31:0] left, input int len);
    logic [31:0] p;
    logic [31:0] t;
    int          n;
    p = left;
    for (int b = 0; b < 32 - len; b++) p[b] = 1'b1;
    n = (len + 7) / 8;
    for (int i = 0; i < n; i++) begin
      t = p >> (24 - 8 * i);
      add_byte(t[7:0]);
    end
`ifdef EOI_APPEND_EN
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hD9);
`endif
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    for (int i = 0; i < 4; i++) begin
      w = {w[23:0], ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255))};
    end
    return w;
  endfunction

  // Output monitor: inputs settle 1 time unit after posedge, so at negedge they show what the
  // coming posedge will sample.
  initial begin
    forever begin
      @(negedge clk_x8_i);
      if (rst_i) begin
        hold_pending = 1'b0;
        prev_eoi     = 1'b0;
      end else begin
        if (hold_pending) begin
          check_eq("hold_valid", 32'(byte_valid_o), 32'd1);
          check_eq("hold_byte", 32'(byte_o), 32'(hold_byte));
        end
        hold_pending = byte_valid_o && !byte_ready_i;
        hold_byte    = byte_o;
        if (byte_valid_o && byte_ready_i) begin
          n_rx++;
          if (exp_q.size() == 0) check_eq("extra_byte", 32'(byte_o), 32'h100);
          else check_eq("byte", 32'(byte_o), 32'(exp_q.pop_front()));
        end
        if (prev_eoi) check_eq("eoi_one_cycle", 32'(eoi_done_o), 32'd0);
        if (eoi_done_o) begin
          n_eoi++;
          check_eq("busy_at_eoi", 32'(busy_o), 32'd0);
        end
        prev_eoi = eoi_done_o;
      end
    end
  end

  task automatic step();
    @(posedge clk_x8_i);
    #1;
    case (rdy_mode)
      0:       byte_ready_i = 1'b0;
      1:       byte_ready_i = 1'b1;
      default: byte_ready_i = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic push_word(input logic [31:0] w, input bit expect_it);
    word_i       = w;
    word_valid_i = 1'b1;
    if (expect_it) model_word(w);
    step();
    word_valid_i = 1'b0;
  endtask

  task automatic send_last(input bit has_w, input logic [31:0] w, input logic [31:0] left,
                           input int len);
    word_i       = w;
    word_valid_i = has_w;
    last_i       = 1'b1;
    left_i       = left;
    left_len_i   = 5'(len);
    if (has_w) model_word(w);
    model_last(left, len);
    step();
    word_valid_i = 1'b0;
    last_i       = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int c = 0;
    while ((exp_q.size() != 0 || byte_valid_o) && c < budget) begin
      step();
      c++;
    end
    check_eq(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_eoi(input string tag, input int base, input int budget);
    int c = 0;
    while (n_eoi == base && c < budget) begin
      step();
      c++;
    end
    check_eq(tag, 32'(n_eoi), 32'(base + 1));
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_byte"}, 32'(byte_o), 32'd0);
    check_eq({tag, "_valid"}, 32'(byte_valid_o), 32'd0);
    check_eq({tag, "_eoi"}, 32'(eoi_done_o), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy_o), 32'd0);
    check_eq({tag, "_ovf"}, 32'(overflow_o), 32'd0);
  endtask

  initial begin
    int          base;
    int          base_e;
    int          nw;
    int          exp_n;
    logic [31:0] w;

    rdy_mode = 1;
    rst_i    = 1'b1;
    repeat (3) step();
    check_reset_vals("reset");
    rst_i = 1'b0;
    step();

    // Latency and order of a plain word.
    push_word(32'h1234_5678, 1'b1);
    check_eq("busy_after_push", 32'(busy_o), 32'd1);
    step();
    check_eq("lat_not_yet", 32'(byte_valid_o), 32'd0);
    step();
    check_eq("lat_valid", 32'(byte_valid_o), 32'd1);
    check_eq("lat_b0", 32'(byte_o), 32'h12);
    step();
    check_eq("b1", 32'(byte_o), 32'h34);
    step();
    check_eq("b2", 32'(byte_o), 32'h56);
    step();
    check_eq("b3", 32'(byte_o), 32'h78);
    wait_drain("drain_plain", 50);

    // Stuffing.
    base = n_rx;
    push_word(32'hFF00_FFAB, 1'b1);
    wait_drain("drain_stuff", 50);
    check_eq("stuff_count", 32'(n_rx - base), 32'd6);

    // Eight words while stalled.
    rdy_mode = 0;
    base = n_rx;
    for (int i = 0; i < 8; i++) push_word(32'h1020_3040 + 32'(i) * 32'h0101_0101, 1'b1);
    repeat (32) step();
    check_eq("stall_no_rx", 32'(n_rx - base), 32'd0);
    check_eq("stall_ovf", 32'(overflow_o), 32'd0);
    rdy_mode = 1;
    wait_drain("drain_stall", 200);
    check_eq("stall_count", 32'(n_rx - base), 32'd32);

    // Word with last_i: residual 7 bits 1111111 pads to 0xFF.
    base_e = n_eoi;
    send_last(1'b1, 32'hA5A5_A5A5, 32'hFE00_0000, 7);
    wait_eoi("eoi_a5", base_e, 200);
    check_eq("a5_left", 32'(exp_q.size()), 32'd0);
    check_eq("a5_busy", 32'(busy_o), 32'd0);

    // Padding example from the rule: 0b10110, 5 bits -> 0xB7.
    base_e = n_eoi;
    send_last(1'b0, 32'h0, 32'hB000_0000, 5);
    wait_eoi("eoi_pad", base_e, 200);
    check_eq("pad_left", 32'(exp_q.size()), 32'd0);

    // Empty residual with an empty FIFO.
    base   = n_rx;
    base_e = n_eoi;
    send_last(1'b0, 32'h0, 32'h0, 0);
`ifndef EOI_APPEND_EN
    step();
    check_eq("len0_eoi_early", 32'(eoi_done_o), 32'd0);
    step();
    check_eq("len0_eoi", 32'(eoi_done_o), 32'd1);
    check_eq("len0_no_bytes", 32'(n_rx - base), 32'd0);
`endif
    wait_eoi("eoi_len0", base_e, 200);

    // Randomized frames.
    rdy_mode = 2;
    for (int f = 0; f < 25; f++) begin
      nw = $urandom_range(0, 10);
      for (int i = 0; i < nw; i++) begin
        push_word(rand_word(), 1'b1);
        repeat ($urandom_range(0, 2)) step();
      end
      base_e = n_eoi;
      w = rand_word();
      send_last(1'($urandom_range(0, 1)), w, $urandom, $urandom_range(0, 31));
      wait_eoi("eoi_rand", base_e, 3000);
      check_eq("rand_left", 32'(exp_q.size()), 32'd0);
    end
    rdy_mode = 1;
    step();
    check_eq("rand_ovf", 32'(overflow_o), 32'd0);

    // Overflow: one word is held in the output stage plus FIFO_DEPTH queued, the rest drop.
    rdy_mode = 0;
    base = n_rx;
    for (int i = 0; i < 20; i++) push_word(rand_word(), i < 17);
    exp_n = exp_q.size();
    check_eq("ovf_set", 32'(overflow_o), 32'd1);
    rdy_mode = 1;
    wait_drain("drain_ovf", 400);
    check_eq("ovf_count", 32'(n_rx - base), 32'(exp_n));
    check_eq("ovf_sticky", 32'(overflow_o), 32'd1);

    rst_i = 1'b1;
    step();
    check_eq("ovf_cleared", 32'(overflow_o), 32'd0);
    rst_i = 1'b0;
    step();

    // Reset mid-frame, in SEND of word 2.
    base = n_rx;
    push_word(32'h1122_3344, 1'b1);
    push_word(32'h5566_7788, 1'b1);
    push_word(32'h99AA_BBCC, 1'b1);
    push_word(32'h0D0E_0F10, 1'b1);
    for (int c = 0; c < 200 && n_rx < base + 5; c++) step();
    check_eq("mid_reached", 32'(n_rx - base), 32'd5);
    rst_i        = 1'b1;
    byte_ready_i = 1'b0;
    exp_q.delete();
    @(posedge clk_x8_i);
    #1;
    check_reset_vals("mid_reset");
    rst_i = 1'b0;
    step();
    repeat (3) step();
    check_eq("mid_quiet", 32'(byte_valid_o), 32'd0);
    base = n_rx;
    push_word(32'h0102_0304, 1'b1);
    wait_drain("drain_fresh", 50);
    repeat (5) step();
    check_eq("fresh_count", 32'(n_rx - base), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
